// File: rtl/arbitro_escritura_breg.sv
// -----------------------------------------------------------------------------
// arbitro_escritura_breg
//
// Shares the single write port of the 32x32 register file between two
// write-back requesters (ALU result and memory load). Each requester feeds a
// small FIFO through a valid/ready handshake. An arbiter commits at most one
// write per cycle into a registered output (enesc/diresc/datoesc). It also
// flags read-after-write hazards for the two register-file read addresses
// against writes that are still queued.
//
// Optional build macro:
//   ARB_ROUNDROBIN_EN : alternating priority between ALU and MEM.
//                       When undefined, MEM has fixed priority and the ALU is
//                       force-granted after MAX_ESPERA consecutive lost cycles.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   val_alu/listo_alu     ALU request handshake, dir_alu/dato_alu payload
//   val_mem/listo_mem     MEM request handshake, dir_mem/dato_mem payload
//   dirlec1/dirlec2       register-file read addresses
//   riesgo1/riesgo2       hazard: read address matches a queued write
//   enesc/diresc/datoesc  register-file write port
//   ocupado               any write queued or in flight
// -----------------------------------------------------------------------------

// Per-requester FIFO with hazard lookup over its valid entries.
module arbitro_escritura_breg_fifo #(
    parameter int ANCHO_DATO  = 32,
    parameter int ANCHO_DIR   = 5,
    parameter int PROFUNDIDAD = 2,
    localparam int PW         = $clog2(PROFUNDIDAD),
    localparam int CW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ANCHO_DIR-1:0]  dir_in,
    input  logic [ANCHO_DATO-1:0] dato_in,
    input  logic                  pop,
    input  logic [ANCHO_DIR-1:0]  dirlec1,
    input  logic [ANCHO_DIR-1:0]  dirlec2,
    output logic [CW-1:0]         count,
    output logic [ANCHO_DIR-1:0]  dir_head,
    output logic [ANCHO_DATO-1:0] dato_head,
    output logic                  hit1,
    output logic                  hit2
);
    logic [ANCHO_DIR-1:0]  dir_q  [PROFUNDIDAD];
    logic [ANCHO_DATO-1:0] dato_q [PROFUNDIDAD];
    logic [PW-1:0]         rd;
    logic [PW-1:0]         wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + PW'(1);
            if (pop)  rd <= rd + PW'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only slots covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            dir_q[wr]  <= dir_in;
            dato_q[wr] <= dato_in;
        end
    end

    assign dir_head  = dir_q[rd];
    assign dato_head = dato_q[rd];

    // Walk from the head so only live entries take part in the comparison.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < PROFUNDIDAD; k++) begin
            if (CW'(k) < count) begin
                if (dir_q[rd + PW'(k)] == dirlec1) hit1 = 1'b1;
                if (dir_q[rd + PW'(k)] == dirlec2) hit2 = 1'b1;
            end
        end
    end
endmodule

module arbitro_escritura_breg #(
    parameter int ANCHO_DATO  = 32,
    parameter int ANCHO_DIR   = 5,
    parameter int PROFUNDIDAD = 2,
    parameter int MAX_ESPERA  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  val_alu,
    output logic                  listo_alu,
    input  logic [ANCHO_DIR-1:0]  dir_alu,
    input  logic [ANCHO_DATO-1:0] dato_alu,
    input  logic                  val_mem,
    output logic                  listo_mem,
    input  logic [ANCHO_DIR-1:0]  dir_mem,
    input  logic [ANCHO_DATO-1:0] dato_mem,
    input  logic [ANCHO_DIR-1:0]  dirlec1,
    input  logic [ANCHO_DIR-1:0]  dirlec2,
    output logic                  riesgo1,
    output logic                  riesgo2,
    output logic                  enesc,
    output logic [ANCHO_DIR-1:0]  diresc,
    output logic [ANCHO_DATO-1:0] datoesc,
    output logic                  ocupado
);
    localparam int PW = $clog2(PROFUNDIDAD);
    localparam int CW = PW + 1;

    logic [CW-1:0]         cnt_alu, cnt_mem;
    logic [ANCHO_DIR-1:0]  cab_dir_alu, cab_dir_mem;
    logic [ANCHO_DATO-1:0] cab_dato_alu, cab_dato_mem;
    logic                  h1_alu, h2_alu, h1_mem, h2_mem;
    logic                  push_alu, push_mem;
    logic                  eleg_alu, eleg_mem;
    logic                  gana_alu, gana_mem;

    // Ready depends on registered occupancy only, so a full FIFO being
    // drained this cycle still reports not-ready.
    assign listo_alu = !rst && (cnt_alu < CW'(PROFUNDIDAD));
    assign listo_mem = !rst && (cnt_mem < CW'(PROFUNDIDAD));
    assign push_alu  = val_alu && listo_alu;
    assign push_mem  = val_mem && listo_mem;

    // Eligibility uses start-of-cycle occupancy: a fresh entry cannot bypass.
    assign eleg_alu = (cnt_alu != '0);
    assign eleg_mem = (cnt_mem != '0);

    arbitro_escritura_breg_fifo #(
        .ANCHO_DATO (ANCHO_DATO),
        .ANCHO_DIR  (ANCHO_DIR),
        .PROFUNDIDAD(PROFUNDIDAD)
    ) u_fifo_alu (
        .clk      (clk),
        .rst      (rst),
        .push     (push_alu),
        .dir_in   (dir_alu),
        .dato_in  (dato_alu),
        .pop      (gana_alu),
        .dirlec1  (dirlec1),
        .dirlec2  (dirlec2),
        .count    (cnt_alu),
        .dir_head (cab_dir_alu),
        .dato_head(cab_dato_alu),
        .hit1     (h1_alu),
        .hit2     (h2_alu)
    );

    arbitro_escritura_breg_fifo #(
        .ANCHO_DATO (ANCHO_DATO),
        .ANCHO_DIR  (ANCHO_DIR),
        .PROFUNDIDAD(PROFUNDIDAD)
    ) u_fifo_mem (
        .clk      (clk),
        .rst      (rst),
        .push     (push_mem),
        .dir_in   (dir_mem),
        .dato_in  (dato_mem),
        .pop      (gana_mem),
        .dirlec1  (dirlec1),
        .dirlec2  (dirlec2),
        .count    (cnt_mem),
        .dir_head (cab_dir_mem),
        .dato_head(cab_dato_mem),
        .hit1     (h1_mem),
        .hit2     (h2_mem)
    );

`ifdef ARB_ROUNDROBIN_EN
    // Last-winner flag; starts as ALU so MEM gets the first tie.
    logic ult_alu;

    always_comb begin
        gana_alu = 1'b0;
        gana_mem = 1'b0;
        if (eleg_alu && eleg_mem) begin
            if (ult_alu) gana_mem = 1'b1;
            else         gana_alu = 1'b1;
        end else if (eleg_mem) begin
            gana_mem = 1'b1;
        end else if (eleg_alu) begin
            gana_alu = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ult_alu <= 1'b1;
        else if (gana_alu) ult_alu <= 1'b1;
        else if (gana_mem) ult_alu <= 1'b0;
    end
`else
    localparam int EW = $clog2(MAX_ESPERA + 1);

    logic [EW-1:0] espera_alu;
    logic          forzar_alu;

    // Ageing override: a starved ALU beats MEM once it has waited long enough.
    assign forzar_alu = eleg_alu && (espera_alu >= EW'(MAX_ESPERA));

    always_comb begin
        gana_alu = forzar_alu || (eleg_alu && !eleg_mem);
        gana_mem = eleg_mem && !forzar_alu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            espera_alu <= '0;
        end else if (eleg_alu && !gana_alu) begin
            if (espera_alu != EW'(MAX_ESPERA)) espera_alu <= espera_alu + EW'(1);
        end else begin
            espera_alu <= '0;
        end
    end
`endif

    // Registered commit. Zero-register writes are consumed without enabling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enesc   <= 1'b0;
            diresc  <= '0;
            datoesc <= '0;
        end else if (gana_alu) begin
            enesc   <= (cab_dir_alu != '0);
            diresc  <= cab_dir_alu;
            datoesc <= cab_dato_alu;
        end else if (gana_mem) begin
            enesc   <= (cab_dir_mem != '0);
            diresc  <= cab_dir_mem;
            datoesc <= cab_dato_mem;
        end else begin
            enesc   <= 1'b0;
        end
    end

    // The entry sitting in the output register is not a hazard: the register
    // file forwards it while enesc is high.
    assign riesgo1 = (dirlec1 != '0) && (h1_alu || h1_mem);
    assign riesgo2 = (dirlec2 != '0) && (h2_alu || h2_mem);

    assign ocupado = eleg_alu || eleg_mem || enesc;
endmodule

// File: tb/tb_arbitro_escritura_breg.sv
module tb_arbitro_escritura_breg;
    localparam int P  = 2;
    localparam int ME = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        val_alu, val_mem;
    logic        listo_alu, listo_mem;
    logic [4:0]  dir_alu, dir_mem, dirlec1, dirlec2, diresc;
    logic [31:0] dato_alu, dato_mem, datoesc;
    logic        riesgo1, riesgo2, enesc, ocupado;

    always #5 clk = ~clk;

    arbitro_escritura_breg #(
        .ANCHO_DATO(32), .ANCHO_DIR(5), .PROFUNDIDAD(P), .MAX_ESPERA(ME)
    ) dut (
        .clk(clk), .rst(rst),
        .val_alu(val_alu), .listo_alu(listo_alu), .dir_alu(dir_alu), .dato_alu(dato_alu),
        .val_mem(val_mem), .listo_mem(listo_mem), .dir_mem(dir_mem), .dato_mem(dato_mem),
        .dirlec1(dirlec1), .dirlec2(dirlec2), .riesgo1(riesgo1), .riesgo2(riesgo2),
        .enesc(enesc), .diresc(diresc), .datoesc(datoesc), .ocupado(ocupado)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t        qa[$];
    ent_t        qm[$];
    logic        m_en;
    logic [4:0]  m_dir;
    logic [31:0] m_dato;
`ifdef ARB_ROUNDROBIN_EN
    bit          m_ult_alu;
`else
    int          m_esp;
`endif

    always @(posedge clk or posedge rst) begin : model
        bit   la, lm;
        int   w;
        ent_t e;
        if (rst) begin
            qa.delete(); qm.delete();
            m_en = 1'b0; m_dir = '0; m_dato = '0;
`ifdef ARB_ROUNDROBIN_EN
            m_ult_alu = 1'b1;
`else
            m_esp = 0;
`endif
        end else begin
            la = (qa.size() < P);
            lm = (qm.size() < P);
            w  = 0;  // 0 none, 1 ALU, 2 MEM
`ifdef ARB_ROUNDROBIN_EN
            if (qa.size() > 0 && qm.size() > 0) w = m_ult_alu ? 2 : 1;
            else if (qm.size() > 0)             w = 2;
            else if (qa.size() > 0)             w = 1;
            if (w == 1) m_ult_alu = 1'b1;
            if (w == 2) m_ult_alu = 1'b0;
`else
            if (qa.size() > 0 && m_esp >= ME) w = 1;
            else if (qm.size() > 0)           w = 2;
            else if (qa.size() > 0)           w = 1;
            if (qa.size() > 0 && w != 1) m_esp = (m_esp < ME) ? m_esp + 1 : ME;
            else                         m_esp = 0;
`endif
            if (w != 0) begin
                e = (w == 1) ? qa.pop_front() : qm.pop_front();
                m_en = (e.d != 0); m_dir = e.d; m_dato = e.v;
            end else begin
                m_en = 1'b0;
            end
            if (val_alu && la) qa.push_back('{dir_alu, dato_alu});
            if (val_mem && lm) qm.push_back('{dir_mem, dato_mem});
        end
    end

    function automatic bit hz(logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (qa[i]) if (qa[i].d == a) return 1'b1;
        foreach (qm[i]) if (qm[i].d == a) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- checking ----------------
    int ncmp = 0;
    int nerr = 0;
    int act_log[$];
    int exp_log[$];

    task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_all();
        cmp("listo_alu", 32'(listo_alu), 32'(!rst && qa.size() < P));
        cmp("listo_mem", 32'(listo_mem), 32'(!rst && qm.size() < P));
        cmp("enesc",     32'(enesc),     32'(m_en));
        cmp("diresc",    32'(diresc),    32'(m_dir));
        cmp("datoesc",   datoesc,        m_dato);
        cmp("riesgo1",   32'(riesgo1),   32'(hz(dirlec1)));
        cmp("riesgo2",   32'(riesgo2),   32'(hz(dirlec2)));
        cmp("ocupado",   32'(ocupado),   32'(qa.size() != 0 || qm.size() != 0 || m_en));
        if (enesc) act_log.push_back(int'(diresc));
        if (m_en)  exp_log.push_back(int'(m_dir));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    int ord[4];
    int n;
    bit found;
    int age_exp;

    initial begin
        rst = 1'b1; val_alu = 0; val_mem = 0;
        dir_alu = 0; dir_mem = 0; dato_alu = 0; dato_mem = 0;
        dirlec1 = 0; dirlec2 = 0;

        // Reset state
        tick(); tick();
        cmp("rst_enesc", 32'(enesc), 32'd0);
        cmp("rst_listo_alu", 32'(listo_alu), 32'd0);
        cmp("rst_listo_mem", 32'(listo_mem), 32'd0);
        cmp("rst_ocupado", 32'(ocupado), 32'd0);
        cmp("rst_diresc", 32'(diresc), 32'd0);
        rst = 1'b0;
        #1 cmp("rel_listo_alu", 32'(listo_alu), 32'd1);

        // Single ALU write: dir 5 / 0xAA
        val_alu = 1; dir_alu = 5; dato_alu = 32'h0000_00AA;
        tick();
        val_alu = 0;
        cmp("t1_e1_enesc", 32'(enesc), 32'd0);
        cmp("t1_e1_ocupado", 32'(ocupado), 32'd1);
        tick();
        cmp("t1_e2_enesc", 32'(enesc), 32'd1);
        cmp("t1_e2_diresc", 32'(diresc), 32'd5);
        cmp("t1_e2_datoesc", datoesc, 32'h0000_00AA);
        tick();
        cmp("t1_e3_enesc", 32'(enesc), 32'd0);
        cmp("t1_e3_ocupado", 32'(ocupado), 32'd0);

        // Both requesters push two entries in the same cycles
        act_log.delete(); exp_log.delete();
        val_alu = 1; dir_alu = 7; dato_alu = 32'h77;
        val_mem = 1; dir_mem = 3; dato_mem = 32'h33;
        tick();
        dir_alu = 8; dato_alu = 32'h88; dir_mem = 4; dato_mem = 32'h44;
        tick();
        val_alu = 0; val_mem = 0;
        repeat (5) tick();
`ifdef ARB_ROUNDROBIN_EN
        ord = '{3, 7, 4, 8};
`else
        ord = '{3, 4, 7, 8};
`endif
        cmp("t2_count", 32'(act_log.size()), 32'd4);
        cmp("t2_model_count", 32'(exp_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("t2_order%0d", i), 32'(act_log.size() > i ? act_log[i] : -1), 32'(ord[i]));
            cmp($sformatf("t2_model_order%0d", i), 32'(exp_log.size() > i ? exp_log[i] : -1), 32'(ord[i]));
        end

        // MEM streams while ALU holds dir 9
        val_mem = 1; dir_mem = 16; dato_mem = 32'h1000;
        val_alu = 1; dir_alu = 9; dato_alu = 32'h99;
        tick();
        val_alu = 0;
        n = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            dir_mem = 5'(17 + (i % 8)); dato_mem = 32'(32'h1001 + i);
            tick();
            n++;
            if (enesc && diresc == 5'd9) found = 1;
        end
`ifdef ARB_ROUNDROBIN_EN
        age_exp = 2;
`else
        age_exp = ME + 1;
`endif
        cmp("t3_alu_wait", 32'(n), 32'(age_exp));
        cmp("t3_alu_data", datoesc, 32'h99);
        val_mem = 0;
        repeat (4) tick();

        // ALU write to register 0
        dirlec1 = 0;
        val_alu = 1; dir_alu = 0; dato_alu = 32'hFFFF_FFFF;
        tick();
        val_alu = 0;
        cmp("t4_riesgo1", 32'(riesgo1), 32'd0);
        cmp("t4_ocupado_q", 32'(ocupado), 32'd1);
        tick();
        cmp("t4_enesc", 32'(enesc), 32'd0);
        cmp("t4_consumed", 32'(ocupado), 32'd0);

        // Hazard on queued dir 12
        dirlec1 = 12; dirlec2 = 13;
        val_alu = 1; dir_alu = 12; dato_alu = 32'h1234;
        tick();
        val_alu = 0;
        cmp("t5_riesgo1_q", 32'(riesgo1), 32'd1);
        cmp("t5_riesgo2_q", 32'(riesgo2), 32'd0);
        tick();
        cmp("t5_enesc", 32'(enesc), 32'd1);
        cmp("t5_diresc", 32'(diresc), 32'd12);
        cmp("t5_riesgo1_out", 32'(riesgo1), 32'd0);
        dirlec1 = 0; dirlec2 = 0;
        tick();

        // Reset in the middle of traffic
        val_mem = 1; dir_mem = 14; dato_mem = 32'hA;
        tick();
        dir_mem = 15; dato_mem = 32'hB; dirlec1 = 15;
        tick();
        val_mem = 0;
        cmp("t6_pre_enesc", 32'(enesc), 32'd1);
        cmp("t6_pre_riesgo1", 32'(riesgo1), 32'd1);
        #2 rst = 1'b1; val_mem = 1; dir_mem = 17;
        #1;
        cmp("t6_rst_enesc", 32'(enesc), 32'd0);
        cmp("t6_rst_listo_mem", 32'(listo_mem), 32'd0);
        cmp("t6_rst_riesgo1", 32'(riesgo1), 32'd0);
        tick(); tick();
        rst = 1'b0; val_mem = 0; dirlec1 = 0;
        act_log.delete();
        #1;
        cmp("t6_rel_listo_mem", 32'(listo_mem), 32'd1);
        cmp("t6_rel_ocupado", 32'(ocupado), 32'd0);
        repeat (3) tick();
        cmp("t6_no_write", 32'(act_log.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/arbitro_escritura_breg.md
Name: arbitro_escritura_breg

Overview:
- Sequences and shares the single write port (enesc/diresc/datoesc) of the 32x32 register file between two write-back requesters: ALU result and memory load.
- Each requester has a small FIFO with a valid/ready handshake; an arbiter commits at most one write per cycle.
- Flags read-after-write hazards for the two register-file read addresses against writes still queued.

Parameters:
- ANCHO_DATO, 32, data width
- ANCHO_DIR, 5, register address width
- PROFUNDIDAD, 2, entries per requester FIFO (power of 2, >=2)
- MAX_ESPERA, 4, consecutive lost cycles before ALU is force-granted

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- val_alu  in  1  ALU write request valid
- listo_alu  out  1  ALU FIFO can accept
- dir_alu  in  ANCHO_DIR  ALU destination register
- dato_alu  in  ANCHO_DATO  ALU write data
- val_mem  in  1  MEM write request valid
- listo_mem  out  1  MEM FIFO can accept
- dir_mem  in  ANCHO_DIR  MEM destination register
- dato_mem  in  ANCHO_DATO  MEM write data
- dirlec1  in  ANCHO_DIR  read address 1 (same net as register file)
- dirlec2  in  ANCHO_DIR  read address 2
- riesgo1  out  1  hazard on dirlec1
- riesgo2  out  1  hazard on dirlec2
- enesc  out  1  register file write enable
- diresc  out  ANCHO_DIR  register file write address
- datoesc  out  ANCHO_DATO  register file write data
- ocupado  out  1  any write queued or in flight

Behaviour:
- Reset, asynchronous: both FIFOs empty; espera_alu=0; enesc=0, diresc=0, datoesc=0; ocupado=0. listo_* forced 0 while rst high. A request presented during reset is dropped.
- Handshake:
  - listo_x = (count_x < PROFUNDIDAD) and not rst. It is computed from registered count only and never depends on a same-cycle dequeue.
  - A transfer occurs on a rising edge with val_x && listo_x. Data and address must hold until the transfer.
- Eligibility and winner selection:
  - A FIFO is eligible only if it was non-empty at the start of the cycle. An entry enqueued at edge k can win at edge k+1 at the earliest, so enesc goes high in the cycle after edge k+1.
  - Default priority: MEM over ALU.
  - If espera_alu >= MAX_ESPERA and the ALU FIFO is non-empty, ALU wins.
- espera_alu counter:
  - Increments, saturating at MAX_ESPERA, each cycle the ALU FIFO is non-empty and loses.
  - Clears when ALU wins or its FIFO is empty.
- Commit, registered:
  - The winner head is dequeued at the edge. diresc/datoesc <= head, and enesc <= 1.
  - Exception: if the head address is 0, enesc <= 0. The entry is still consumed (writes to the zero register are discarded).
  - With no winner: enesc <= 0, and diresc/datoesc hold their values.
- Per-requester ordering: FIFO order is strict. Cross-requester ordering follows arbitration only; producers must not have the same destination pending in both FIFOs.
- Simultaneous events: a full FIFO dequeued this cycle still shows listo=0 this cycle. Enqueue and dequeue on the same FIFO in one edge are both performed, so count is unchanged.
- Hazards, combinational:
  - riesgo_i = (dirlec_i != 0) and dirlec_i equals the address of any valid entry in either FIFO.
  - An entry already in the output register is not a hazard, because the register file writes combinationally while enesc=1.
- ocupado = (count_alu != 0) | (count_mem != 0) | enesc.
- Reset mid-operation: all queued writes are lost, enesc drops immediately, and no partial write occurs.

Optional Feature:
- ARB_ROUNDROBIN_EN defined:
  - Replaces fixed priority and ageing with alternating priority. A last-winner flag, reset to ALU so that MEM has first priority, gives the other requester priority when both are eligible.
  - espera_alu is not implemented.
- Undefined: fixed MEM priority with MAX_ESPERA ageing, as above.

Test Plan:
- Reset, then single ALU request dir=5 data=0x0000_00AA at edge 1 -> enesc=1, diresc=5, datoesc=0xAA during cycle after edge 2; enesc=0 the next cycle; ocupado falls after that.
- Both requesters each push 2 entries (MEM dir 3,4; ALU dir 7,8) in the same cycles -> commit order 3,4,7,8 (fixed priority); with ARB_ROUNDROBIN_EN the order is 3,7,4,8.
- MEM streams continuously with val_mem=1 while ALU holds one entry dir=9 -> ALU commits after exactly MAX_ESPERA=4 lost cycles, i.e. on the 5th arbitration cycle.
- ALU writes dir=0 data=0xFFFF_FFFF -> entry consumed, enesc stays 0, and riesgo never asserts for dirlec1=0.
- Queue ALU dir=12, hold dirlec1=12, dirlec2=13 -> riesgo1=1 and riesgo2=0 while the entry is queued; riesgo1=0 in the cycle enesc=1 for dir 12.
- Fill MEM FIFO (2 entries), assert rst asynchronously mid-cycle -> enesc=0, listo_mem=0 immediately; after release, listo_mem=1, ocupado=0, and no write from the flushed entries.
